// File: rtl/llki_pkg.sv
// Shared types and constants for the LLKI technique-specific shim key-load logic.
package llki_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD_WAIT  = 3'd1,
    WAIT_NEXT  = 3'd2,
    LOADED     = 3'd3,
    CLEAR      = 3'd4,
    CLEAR_WAIT = 3'd5
  } TSS_KEYLOAD_STATE_TYPE;

  localparam int DEFAULT_LOAD_WAIT_CYCLES  = 4;
  localparam int DEFAULT_CLEAR_WAIT_CYCLES = 8;

  // Maps the arrival index of a key word to its 64-bit slot in the key register.
  function automatic int key_slot(input int idx, input int key_words, input bit msw_first);
    return msw_first ? (key_words - 1 - idx) : idx;
  endfunction

endpackage

// File: rtl/llki_tss_keyload_fsm_if.sv
// LLKI discrete key-load interface between the SRoT (master) and a shim (slave).
interface llki_tss_keyload_fsm_if #(
  parameter int KEY_WORDS = 2
);

  // A key word transfers on any clk edge where llkid_key_valid and
  // llkid_key_ready are both high; the master holds data stable while valid.
  logic [63:0]             llkid_key_data;
  logic                    llkid_key_valid;
  logic                    llkid_key_ready;
  logic                    llkid_key_complete;
  logic                    llkid_clear_key;
  logic                    llkid_clear_key_ack;
  logic [64*KEY_WORDS-1:0] llkid_key_register;

  modport master (
    output llkid_key_data, llkid_key_valid, llkid_clear_key,
    input  llkid_key_ready, llkid_key_complete, llkid_clear_key_ack, llkid_key_register
  );

  modport slave (
    input  llkid_key_data, llkid_key_valid, llkid_clear_key,
    output llkid_key_ready, llkid_key_complete, llkid_clear_key_ack, llkid_key_register
  );

endinterface

// File: rtl/llki_wait_counter.sv
// 8-bit loadable down-counter; holds at zero once it gets there.
module llki_wait_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       enable,
  output logic       zero
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/llki_tss_keyload_fsm.sv
// Key-load state machine for the LLKI technique-specific shim: assembles key words,
// holds the loaded key, flags overloads and runs the clear/ack handshake.
module llki_tss_keyload_fsm
  import llki_pkg::*;
#(
  parameter int KEY_WORDS         = 2,
  parameter int LOAD_WAIT_CYCLES  = DEFAULT_LOAD_WAIT_CYCLES,
  parameter int CLEAR_WAIT_CYCLES = DEFAULT_CLEAR_WAIT_CYCLES,
  parameter int LOAD_MSW_FIRST    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  llki_tss_keyload_fsm_if.slave llkid,
  output logic                  key_error,
  output logic [7:0]            word_count,
  output TSS_KEYLOAD_STATE_TYPE fsm_state
);

  localparam logic [7:0] KEY_WORDS_8 = 8'(KEY_WORDS);

  logic                    ready;
  logic                    complete;
  logic                    ack;
  logic                    clear_armed;
  logic [64*KEY_WORDS-1:0] key_reg;

  logic       clear_hit;
  logic       accept;
  int         wr_slot;
  logic       cnt_load;
  logic [7:0] cnt_load_value;
  logic       cnt_enable;
  logic       cnt_zero;

  // Clear is ignored while one is already in progress so a held request cannot restart it.
  always_comb begin
    clear_hit = clear_armed && llkid.llkid_clear_key &&
                (fsm_state != CLEAR) && (fsm_state != CLEAR_WAIT);
    accept    = llkid.llkid_key_valid && ready && !(clear_armed && llkid.llkid_clear_key);
    wr_slot   = key_slot((fsm_state == IDLE) ? 0 : int'(word_count), KEY_WORDS,
                         LOAD_MSW_FIRST != 0);
    cnt_load  = (accept && ((fsm_state == IDLE) || (fsm_state == WAIT_NEXT))) ||
                (fsm_state == CLEAR);
    cnt_load_value = (fsm_state == CLEAR) ? 8'(CLEAR_WAIT_CYCLES) : 8'(LOAD_WAIT_CYCLES);
    cnt_enable     = (fsm_state == LOAD_WAIT) || (fsm_state == CLEAR_WAIT);
  end

  llki_wait_counter u_wait_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .enable     (cnt_enable),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_state   <= IDLE;
      ready       <= 1'b1;
      complete    <= 1'b0;
      ack         <= 1'b0;
      key_reg     <= '0;
      key_error   <= 1'b0;
      word_count  <= 8'd0;
      clear_armed <= 1'b1;
    end else begin
      ack <= 1'b0;
      if (!llkid.llkid_clear_key) begin
        clear_armed <= 1'b1;
      end
      if (clear_hit) begin
        fsm_state  <= CLEAR;
        ready      <= 1'b0;
        complete   <= 1'b0;
        key_reg    <= '0;
        key_error  <= 1'b0;
        word_count <= 8'd0;
      end else begin
        case (fsm_state)
          IDLE, WAIT_NEXT: begin
            if (accept) begin
              key_reg[64*wr_slot +: 64] <= llkid.llkid_key_data;
              word_count <= word_count + 8'd1;
              fsm_state  <= LOAD_WAIT;
              ready      <= 1'b0;
            end
          end
          LOAD_WAIT: begin
            if (cnt_zero) begin
              ready <= 1'b1;
              if (word_count == KEY_WORDS_8) begin
                fsm_state <= LOADED;
                complete  <= 1'b1;
              end else begin
                fsm_state <= WAIT_NEXT;
              end
            end
          end
          LOADED: begin
            if (accept) begin
              key_error <= 1'b1;
            end
          end
          CLEAR: begin
            fsm_state <= CLEAR_WAIT;
          end
          CLEAR_WAIT: begin
            // Disarm on exit: the requester must drop clear before another is honoured.
            if (cnt_zero) begin
              fsm_state   <= IDLE;
              ready       <= 1'b1;
              ack         <= 1'b1;
              clear_armed <= 1'b0;
            end
          end
          default: begin
            fsm_state   <= IDLE;
            ready       <= 1'b1;
            complete    <= 1'b0;
            key_reg     <= '0;
            key_error   <= 1'b0;
            word_count  <= 8'd0;
            clear_armed <= 1'b1;
          end
        endcase
      end
    end
  end

  assign llkid.llkid_key_ready     = ready;
  assign llkid.llkid_key_complete  = complete;
  assign llkid.llkid_clear_key_ack = ack;
  assign llkid.llkid_key_register  = key_reg;

endmodule

// File: tb/tb_llki_tss_keyload_fsm.sv
// Directed bench for llki_tss_keyload_fsm: LSW/MSW word order, overload, clears and reset.
module tb_llki_tss_keyload_fsm;
  import llki_pkg::*;

  localparam logic [63:0] W1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] W2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] W3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] W4 = 64'h4444_4444_4444_4444;

  logic clk;
  logic rst_n;
  logic rst_n_c;
  int   n_cmp;
  int   n_bad;

  logic                  err_a, err_b, err_c;
  logic [7:0]            wc_a, wc_b, wc_c;
  TSS_KEYLOAD_STATE_TYPE st_a, st_b, st_c;

  llki_tss_keyload_fsm_if #(.KEY_WORDS(2)) if_a ();
  llki_tss_keyload_fsm_if #(.KEY_WORDS(2)) if_b ();
  llki_tss_keyload_fsm_if #(.KEY_WORDS(4)) if_c ();

  assign if_b.llkid_key_data  = if_a.llkid_key_data;
  assign if_b.llkid_key_valid = if_a.llkid_key_valid;
  assign if_b.llkid_clear_key = if_a.llkid_clear_key;

  llki_tss_keyload_fsm #(.KEY_WORDS(2), .LOAD_WAIT_CYCLES(4), .CLEAR_WAIT_CYCLES(8),
                         .LOAD_MSW_FIRST(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .llkid(if_a.slave),
    .key_error(err_a), .word_count(wc_a), .fsm_state(st_a));

  llki_tss_keyload_fsm #(.KEY_WORDS(2), .LOAD_WAIT_CYCLES(4), .CLEAR_WAIT_CYCLES(8),
                         .LOAD_MSW_FIRST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .llkid(if_b.slave),
    .key_error(err_b), .word_count(wc_b), .fsm_state(st_b));

  llki_tss_keyload_fsm #(.KEY_WORDS(4), .LOAD_WAIT_CYCLES(4), .CLEAR_WAIT_CYCLES(8),
                         .LOAD_MSW_FIRST(0)) dut_c (
    .clk(clk), .rst_n(rst_n_c), .llkid(if_c.slave),
    .key_error(err_c), .word_count(wc_c), .fsm_state(st_c));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- drivers ----------------
  task automatic send_c(input logic [63:0] d);
    int t;
    t = 0;
    while (if_c.llkid_key_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_c_timeout: ready=%b want 1", if_c.llkid_key_ready);
    end else begin
      if_c.llkid_key_valid = 1'b1;
      if_c.llkid_key_data  = d;
      @(negedge clk);
      if_c.llkid_key_valid = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    rst_n_c = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({if_a.llkid_key_ready, if_a.llkid_key_complete, if_a.llkid_clear_key_ack, err_a} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_flags_a: got %b want 1000", {if_a.llkid_key_ready,
               if_a.llkid_key_complete, if_a.llkid_clear_key_ack, err_a});
    end
    n_cmp++;
    if (if_a.llkid_key_register !== 128'h0 || wc_a !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_reg_a: reg=%h wc=%0d want 0/0", if_a.llkid_key_register, wc_a);
    end
    n_cmp++;
    if (st_a !== IDLE || st_b !== IDLE || st_c !== IDLE) begin
      n_bad++;
      $display("FAIL reset_state: a=%0d b=%0d c=%0d want IDLE", st_a, st_b, st_c);
    end
    n_cmp++;
    if ({if_c.llkid_key_ready, if_c.llkid_key_complete, err_c, wc_c} !== {3'b100, 8'd0}) begin
      n_bad++;
      $display("FAIL reset_c: got %b want 100_00000000", {if_c.llkid_key_ready,
               if_c.llkid_key_complete, err_c, wc_c});
    end
    rst_n = 1'b1;
    rst_n_c = 1'b1;
    @(negedge clk);
  endtask

  // Two words, both word orders; ready/complete timing relative to the first accept.
  task automatic test_load_order;
    if_a.llkid_key_valid = 1'b1;
    if_a.llkid_key_data  = W1;
    @(negedge clk);  // n=1, first accept happened at the preceding edge
    if_a.llkid_key_valid = 1'b0;
    n_cmp++;
    if (if_a.llkid_key_ready !== 1'b0 || wc_a !== 8'd1 || if_a.llkid_key_register !== {64'h0, W1}) begin
      n_bad++;
      $display("FAIL load_first_word: ready=%b wc=%0d reg=%h want 0/1/%h", if_a.llkid_key_ready,
               wc_a, if_a.llkid_key_register, {64'h0, W1});
    end
    n_cmp++;
    if (if_b.llkid_key_register !== {W1, 64'h0}) begin
      n_bad++;
      $display("FAIL load_first_word_msw: reg=%h want %h", if_b.llkid_key_register, {W1, 64'h0});
    end
    repeat (4) @(negedge clk);  // n=5
    n_cmp++;
    if (if_a.llkid_key_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL ready_low_end: got %b want 0", if_a.llkid_key_ready);
    end
    @(negedge clk);  // n=6
    n_cmp++;
    if (if_a.llkid_key_ready !== 1'b1 || st_a !== WAIT_NEXT) begin
      n_bad++;
      $display("FAIL ready_high_again: ready=%b st=%0d want 1/WAIT_NEXT", if_a.llkid_key_ready, st_a);
    end
    if_a.llkid_key_valid = 1'b1;
    if_a.llkid_key_data  = W2;
    @(negedge clk);  // n=7
    if_a.llkid_key_valid = 1'b0;
    repeat (4) @(negedge clk);  // n=11
    n_cmp++;
    if (if_a.llkid_key_complete !== 1'b0) begin
      n_bad++;
      $display("FAIL complete_early: got %b want 0", if_a.llkid_key_complete);
    end
    @(negedge clk);  // n=12
    n_cmp++;
    if (if_a.llkid_key_complete !== 1'b1 || wc_a !== 8'd2) begin
      n_bad++;
      $display("FAIL complete_rise: complete=%b wc=%0d want 1/2", if_a.llkid_key_complete, wc_a);
    end
    n_cmp++;
    if (if_a.llkid_key_register !== {W2, W1}) begin
      n_bad++;
      $display("FAIL key_lsw_first: reg=%h want %h", if_a.llkid_key_register, {W2, W1});
    end
    n_cmp++;
    if (if_b.llkid_key_register !== {W1, W2} || if_b.llkid_key_complete !== 1'b1) begin
      n_bad++;
      $display("FAIL key_msw_first: reg=%h complete=%b want %h/1", if_b.llkid_key_register,
               if_b.llkid_key_complete, {W1, W2});
    end
  endtask

  task automatic test_overload;
    if_a.llkid_key_valid = 1'b1;
    if_a.llkid_key_data  = W3;
    @(negedge clk);
    if_a.llkid_key_valid = 1'b0;
    n_cmp++;
    if (err_a !== 1'b1 || err_b !== 1'b1) begin
      n_bad++;
      $display("FAIL overload_error: a=%b b=%b want 1/1", err_a, err_b);
    end
    n_cmp++;
    if (if_a.llkid_key_register !== {W2, W1} || wc_a !== 8'd2 || if_a.llkid_key_complete !== 1'b1) begin
      n_bad++;
      $display("FAIL overload_hold: reg=%h wc=%0d complete=%b want %h/2/1",
               if_a.llkid_key_register, wc_a, if_a.llkid_key_complete, {W2, W1});
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (err_a !== 1'b1) begin
      n_bad++;
      $display("FAIL overload_sticky: got %b want 1", err_a);
    end
  endtask

  task automatic test_clear_from_loaded;
    if_a.llkid_clear_key = 1'b1;
    @(negedge clk);  // n=1, clear sampled at the preceding edge
    if_a.llkid_clear_key = 1'b0;
    n_cmp++;
    if (if_a.llkid_key_register !== 128'h0 || err_a !== 1'b0 || wc_a !== 8'd0 ||
        if_a.llkid_key_complete !== 1'b0 || if_a.llkid_key_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_loaded_zero: reg=%h err=%b wc=%0d complete=%b ready=%b want all 0",
               if_a.llkid_key_register, err_a, wc_a, if_a.llkid_key_complete, if_a.llkid_key_ready);
    end
    for (int n = 2; n <= 12; n++) begin
      @(negedge clk);
      if (n == 10) begin
        n_cmp++;
        if (if_a.llkid_clear_key_ack !== 1'b0) begin
          n_bad++;
          $display("FAIL clear_ack_early: got %b want 0", if_a.llkid_clear_key_ack);
        end
      end
      if (n == 11) begin
        n_cmp++;
        if (if_a.llkid_clear_key_ack !== 1'b1 || if_b.llkid_clear_key_ack !== 1'b1 ||
            if_a.llkid_key_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL clear_ack_pulse: a=%b b=%b ready=%b want 1/1/1",
                   if_a.llkid_clear_key_ack, if_b.llkid_clear_key_ack, if_a.llkid_key_ready);
        end
      end
      if (n == 12) begin
        n_cmp++;
        if (if_a.llkid_clear_key_ack !== 1'b0) begin
          n_bad++;
          $display("FAIL clear_ack_width: got %b want 0", if_a.llkid_clear_key_ack);
        end
      end
    end
  endtask

  task automatic test_clear_mid_load;
    if_a.llkid_key_valid = 1'b1;
    if_a.llkid_key_data  = W1;
    @(negedge clk);  // n=1
    if_a.llkid_key_valid = 1'b0;
    n_cmp++;
    if (if_a.llkid_key_register !== {64'h0, W1} || wc_a !== 8'd1) begin
      n_bad++;
      $display("FAIL midload_word: reg=%h wc=%0d want %h/1", if_a.llkid_key_register, wc_a,
               {64'h0, W1});
    end
    repeat (2) @(negedge clk);  // n=3, third cycle of LOAD_WAIT
    n_cmp++;
    if (st_a !== LOAD_WAIT) begin
      n_bad++;
      $display("FAIL midload_state: got %0d want LOAD_WAIT", st_a);
    end
    if_a.llkid_clear_key = 1'b1;
    @(negedge clk);  // n=4
    if_a.llkid_clear_key = 1'b0;
    n_cmp++;
    if (if_a.llkid_key_register !== 128'h0 || wc_a !== 8'd0 || st_a !== CLEAR) begin
      n_bad++;
      $display("FAIL midload_clear: reg=%h wc=%0d st=%0d want 0/0/CLEAR",
               if_a.llkid_key_register, wc_a, st_a);
    end
    for (int n = 5; n <= 15; n++) begin
      @(negedge clk);
      if (n == 13) begin
        n_cmp++;
        if (if_a.llkid_clear_key_ack !== 1'b0) begin
          n_bad++;
          $display("FAIL midload_ack_early: got %b want 0", if_a.llkid_clear_key_ack);
        end
      end
      if (n == 14) begin
        n_cmp++;
        if (if_a.llkid_clear_key_ack !== 1'b1) begin
          n_bad++;
          $display("FAIL midload_ack: got %b want 1", if_a.llkid_clear_key_ack);
        end
      end
      if (n == 15) begin
        n_cmp++;
        if (if_a.llkid_clear_key_ack !== 1'b0 || st_a !== IDLE) begin
          n_bad++;
          $display("FAIL midload_ack_width: ack=%b st=%0d want 0/IDLE",
                   if_a.llkid_clear_key_ack, st_a);
        end
      end
    end
  endtask

  task automatic test_held_clear;
    int acks;
    acks = 0;
    if_a.llkid_clear_key = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (if_a.llkid_clear_key_ack === 1'b1) acks++;
    end
    n_cmp++;
    if (acks !== 1) begin
      n_bad++;
      $display("FAIL held_clear_acks: got %0d want 1", acks);
    end
    if_a.llkid_clear_key = 1'b0;
    repeat (3) @(negedge clk);
    acks = 0;
    if_a.llkid_clear_key = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (if_a.llkid_clear_key_ack === 1'b1) acks++;
    end
    if_a.llkid_clear_key = 1'b0;
    n_cmp++;
    if (acks !== 1) begin
      n_bad++;
      $display("FAIL rearmed_clear_acks: got %0d want 1", acks);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_load;
    int acks;
    int wait_cyc;
    acks = 0;
    send_c(W1);  // returns one negedge after the accepting edge
    @(negedge clk);
    rst_n_c = 1'b0;
    @(negedge clk);
    rst_n_c = 1'b1;
    n_cmp++;
    if ({if_c.llkid_key_ready, if_c.llkid_key_complete, if_c.llkid_clear_key_ack, err_c} !== 4'b1000 ||
        wc_c !== 8'd0 || if_c.llkid_key_register !== 256'h0 || st_c !== IDLE) begin
      n_bad++;
      $display("FAIL rst_mid_load: flags=%b wc=%0d reg=%h st=%0d want 1000/0/0/IDLE",
               {if_c.llkid_key_ready, if_c.llkid_key_complete, if_c.llkid_clear_key_ack, err_c},
               wc_c, if_c.llkid_key_register, st_c);
    end
    send_c(W1);
    send_c(W2);
    send_c(W3);
    send_c(W4);
    wait_cyc = 0;
    while (if_c.llkid_key_complete !== 1'b1 && wait_cyc < 100) begin
      @(negedge clk);
      wait_cyc++;
      if (if_c.llkid_clear_key_ack === 1'b1) acks++;
    end
    n_cmp++;
    if (wait_cyc !== 5) begin
      n_bad++;
      $display("FAIL c_complete_latency: got %0d want 5", wait_cyc);
    end
    n_cmp++;
    if (if_c.llkid_key_register !== {W4, W3, W2, W1} || wc_c !== 8'd4 || err_c !== 1'b0) begin
      n_bad++;
      $display("FAIL c_key: reg=%h wc=%0d err=%b want %h/4/0", if_c.llkid_key_register, wc_c,
               err_c, {W4, W3, W2, W1});
    end
    n_cmp++;
    if (acks !== 0) begin
      n_bad++;
      $display("FAIL c_spurious_ack: got %0d want 0", acks);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    rst_n_c = 1'b0;
    if_a.llkid_key_data  = 64'h0;
    if_a.llkid_key_valid = 1'b0;
    if_a.llkid_clear_key = 1'b0;
    if_c.llkid_key_data  = 64'h0;
    if_c.llkid_key_valid = 1'b0;
    if_c.llkid_clear_key = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_order();
    test_overload();
    test_clear_from_loaded();
    test_clear_mid_load();
    test_held_clear();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/llki_tss_keyload_fsm.md
# llki_tss_keyload_fsm

Parametrised successor to the mock Technique Specific Shim key-load state machine used by every LLKI-protected core. It accepts 64-bit key words from the SRoT over the LLKI discrete valid/ready interface. It assembles the words into a key register with configurable word order and wait states, and reports completion. Beyond the earlier FSM, it adds a held loaded state, overload error detection, a re-armed clear handshake, and a word-count status output.

## Interface
Parameters:
- KEY_WORDS, 2, number of 64-bit key words (1..255).
- LOAD_WAIT_CYCLES, 4, extra wait cycles after each accepted word (0..255).
- CLEAR_WAIT_CYCLES, 8, extra wait cycles during a clear (0..255).
- LOAD_MSW_FIRST, 0, word order. 0: word i lands in bits [64*i +: 64]. 1: word i lands in bits [64*(KEY_WORDS-1-i) +: 64].

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  reset; synchronous, active-low.
- llkid_key_data  in  64  key word.
- llkid_key_valid  in  1  key word valid.
- llkid_key_ready  out  1  registered; shim can accept a word.
- llkid_key_complete  out  1  level; all KEY_WORDS words are loaded.
- llkid_clear_key  in  1  clear request (level).
- llkid_clear_key_ack  out  1  one-cycle pulse when a clear finishes.
- llkid_key_register  out  64*KEY_WORDS  assembled key.
- key_error  out  1  sticky overload flag.
- word_count  out  8  number of words accepted since the last clear.

## Operation
- Reset values (rst_n low at a clk edge): state IDLE, ready=1, complete=0, ack=0, register=0, key_error=0, word_count=0, clear_armed=1.
- Accept rule: a word is accepted when valid && ready && !(clear_armed && llkid_clear_key) is sampled at a clk edge. A clear that coincides with a word takes priority; that word is dropped.
- IDLE (ready=1): on accept, write the slot for word 0, set word_count=1, go to LOAD_WAIT.
- LOAD_WAIT (ready=0):
  - Counter is loaded with LOAD_WAIT_CYCLES on entry and decrements each cycle.
  - When the counter is 0: if word_count==KEY_WORDS, go to LOADED; otherwise go to WAIT_NEXT.
- WAIT_NEXT (ready=1): on accept, write slot word_count, increment word_count, go to LOAD_WAIT.
- LOADED (ready=1, complete=1):
  - Holds the key indefinitely.
  - Any accepted word is discarded and sets key_error. The register and word_count do not change.
- Clear:
  - Recognised in every state when llkid_clear_key && clear_armed, including mid-LOAD_WAIT. Clear always takes priority over counter expiry.
  - Next state is CLEAR: register=0, word_count=0, complete=0, key_error=0, ready=0.
  - Then CLEAR_WAIT (ready=0) for CLEAR_WAIT_CYCLES+1 cycles.
  - Then IDLE, with ack pulsed high for the first IDLE cycle and clear_armed=0.
- Re-arm: clear_armed returns to 1 on the first edge at which llkid_clear_key is sampled low. A held clear therefore produces exactly one ack.
- Illegal state encoding: force IDLE with reset values.
- word_count is 8 bits wide and never wraps, because KEY_WORDS is at most 255.

## Timing
- A word accepted at edge T appears in the register after edge T. Ready is low from T through T+LOAD_WAIT_CYCLES+1, and returns high after edge T+LOAD_WAIT_CYCLES+1.
- Complete rises after edge T+LOAD_WAIT_CYCLES+1 following the final word. Total load time is at least KEY_WORDS*(LOAD_WAIT_CYCLES+2) cycles.
- Clear sampled at edge C:
  - Register is zero after C+1.
  - ack is high for the cycle after edge C+CLEAR_WAIT_CYCLES+2.
- rst_n low mid-operation: all state returns to reset values at that edge. A partial key is discarded and no ack is generated.
- Outputs never depend combinationally on inputs.

## Structure
- llki_pkg gains:
  - TSS_KEYLOAD_STATE_TYPE enum: IDLE, LOAD_WAIT, WAIT_NEXT, LOADED, CLEAR, CLEAR_WAIT.
  - Default wait-count constants.
- Sub-module llki_wait_counter: an 8-bit loadable down-counter with load/enable/zero signals, instanced once and shared by LOAD_WAIT and CLEAR_WAIT.

## Test plan
- KEY_WORDS=2, LOAD_MSW_FIRST=0, words 0x1111…, 0x2222… -> register = {0x2222…,0x1111…}; complete rises 12 cycles after the first accept with LOAD_WAIT_CYCLES=4; word_count=2.
- Same words with LOAD_MSW_FIRST=1 -> register = {0x1111…,0x2222…}.
- Extra word 0x3333… sent in LOADED -> key_error=1, register unchanged, complete stays 1.
- Clear asserted in the third cycle of LOAD_WAIT -> register=0 next cycle; ack is a single pulse exactly CLEAR_WAIT_CYCLES+2 cycles after the sampling edge; key_error cleared.
- Clear held high for 50 cycles -> exactly one ack; a second ack follows only after clear goes low and then high again.
- rst_n pulsed low after word 1 of 4 -> all outputs at reset values; a fresh 4-word load then completes normally.
